// File: rtl/lsu_mem_port.sv
// Load/store unit memory port: request/grant/response bus master with byte lanes and load extension.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and report misaligned in DONE.
module lsu_mem_port #(
   parameter int TIMEOUT = 255,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              mem_write,
   input  logic [1:0]        access_mode,
   input  logic              unsigned_load,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              stall,
   output logic [31:0]       rdata,
   output logic              misaligned,
   output logic              bus_err,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   input  logic              bus_gnt,
   input  logic              bus_rvalid,
   input  logic [31:0]       bus_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t        st;
   logic [CW-1:0] cnt;
   logic [1:0]    r_lane;
   logic [1:0]    r_mode;
   logic          r_uns;
   logic [3:0]    be_n;
   logic [31:0]   wd_n;
   logic          tmo_hit;

`ifdef MISALIGN_TRAP_EN
   logic misal;
   assign misal = ((access_mode == 2'b01) && addr[0]) || (access_mode[1] && (addr[1:0] != 2'b00));
`endif

   assign tmo_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

   // Reset wins over a held req_valid so the core is released immediately.
   always_comb begin
      stall = 1'b0;
      if (!reset) begin
         case (st)
            IDLE:     stall = req_valid;
            REQ,
            WAIT:     stall = 1'b1;
            default:  stall = 1'b0;
         endcase
      end
   end

   always_comb begin
      be_n = 4'hF;
      wd_n = wdata;
      case (access_mode)
         2'b00: begin
            be_n = 4'b0001 << addr[1:0];
            wd_n = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_n = addr[1] ? 4'b1100 : 4'b0011;
            wd_n = {2{wdata[15:0]}};
         end
         default: begin
            be_n = 4'hF;
            wd_n = wdata;
         end
      endcase
   end

   function automatic logic [31:0] load_ext(input logic [1:0] mode, input logic [1:0] lane,
                                            input logic uns, input logic [31:0] d);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = d[7:0];
         2'd1:    b = d[15:8];
         2'd2:    b = d[23:16];
         default: b = d[31:24];
      endcase
      h = lane[1] ? d[31:16] : d[15:0];
      case (mode)
         2'b00:   load_ext = uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   load_ext = uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: load_ext = d;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st         <= IDLE;
         cnt        <= '0;
         r_lane     <= 2'd0;
         r_mode     <= 2'd0;
         r_uns      <= 1'b0;
         rdata      <= 32'd0;
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_addr   <= '0;
         bus_be     <= 4'd0;
         bus_wdata  <= 32'd0;
      end else begin
         case (st)
            IDLE: begin
               if (req_valid) begin
                  r_lane    <= addr[1:0];
                  r_mode    <= access_mode;
                  r_uns     <= unsigned_load;
                  bus_we    <= mem_write;
                  bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                  bus_be    <= be_n;
                  bus_wdata <= wd_n;
                  cnt       <= '0;
`ifdef MISALIGN_TRAP_EN
                  if (misal) begin
                     st         <= DONE;
                     misaligned <= 1'b1;
                  end else
`endif
                  begin
                     st      <= REQ;
                     bus_req <= 1'b1;
                  end
               end
            end
            REQ: begin
               if (bus_gnt) begin
                  bus_req <= 1'b0;
                  cnt     <= '0;
                  if (bus_we) begin
                     st <= DONE;
                  end else if (bus_rvalid) begin
                     rdata <= load_ext(r_mode, r_lane, r_uns, bus_rdata);
                     st    <= DONE;
                  end else begin
                     st <= WAIT;
                  end
               end else if (tmo_hit) begin
                  bus_req <= 1'b0;
                  bus_err <= 1'b1;
                  rdata   <= 32'd0;
                  st      <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT: begin
               if (bus_rvalid) begin
                  rdata <= load_ext(r_mode, r_lane, r_uns, bus_rdata);
                  st    <= DONE;
               end else if (tmo_hit) begin
                  bus_err <= 1'b1;
                  rdata   <= 32'd0;
                  st      <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               rdata      <= 32'd0;
               misaligned <= 1'b0;
               bus_err    <= 1'b0;
               st         <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port: bench acts as core and as bus slave, TIMEOUT fixed at 8.
module tb_lsu_mem_port;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, mem_write, unsigned_load;
   logic [1:0]  access_mode;
   logic [31:0] addr, wdata;
   logic        stall, misaligned, bus_err, bus_req, bus_we;
   logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;
   logic        bus_gnt, bus_rvalid;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        mis;
      int          stall_cyc;
      int          req_cyc;
      logic [31:0] baddr;
      logic [3:0]  be;
      logic [31:0] bwd;
      logic        we;
   } exp_t;

   exp_t exp_q[$];

   lsu_mem_port #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .mem_write(mem_write),
      .access_mode(access_mode), .unsigned_load(unsigned_load), .addr(addr), .wdata(wdata),
      .stall(stall), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic is_misal(input logic [1:0] mode, input logic [31:0] a);
      return (mode == 2'b01 && a[0]) || (mode[1] && a[1:0] != 2'b00);
   endfunction

   // gnt_dly/rv_dly < 0 means the bus never answers that phase.
   task automatic run_access(input string tag, input logic we, input logic [1:0] mode,
                             input logic uns, input logic [31:0] a, input logic [31:0] wd,
                             input int gnt_dly, input bit rv_with_gnt, input int rv_dly,
                             input logic [31:0] brd);
      exp_t e;
      logic [31:0] sh;
      logic [4:0]  lane8;
      bit trap, req_tmo, wait_tmo, done;
      int nreq, nwait, stc;
      trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
      trap = is_misal(mode, a);
`endif
      req_tmo  = !trap && (gnt_dly < 0 || gnt_dly >= TMO);
      wait_tmo = !trap && !req_tmo && !we && !rv_with_gnt && (rv_dly < 0 || rv_dly >= TMO);
      e.baddr = {a[31:2], 2'b00};
      e.we    = we;
      case (mode)
         2'b00:   begin e.be = 4'b0001 << a[1:0];         e.bwd = {4{wd[7:0]}};  lane8 = {a[1:0], 3'b000}; end
         2'b01:   begin e.be = 4'b0011 << {a[1], 1'b0};   e.bwd = {2{wd[15:0]}}; lane8 = {a[1], 4'b0000}; end
         default: begin e.be = 4'b1111;                   e.bwd = wd;            lane8 = 5'd0; end
      endcase
      sh = brd >> lane8;
      if (mode == 2'b00)      e.rdata = uns ? (sh & 32'hFF)   : {{24{sh[7]}}, sh[7:0]};
      else if (mode == 2'b01) e.rdata = uns ? (sh & 32'hFFFF) : {{16{sh[15]}}, sh[15:0]};
      else                    e.rdata = brd;
      if (we || trap || req_tmo || wait_tmo) e.rdata = 32'd0;
      e.err = req_tmo || wait_tmo;
      e.mis = trap;
      if (trap)         begin e.stall_cyc = 1;       e.req_cyc = 0;   end
      else if (req_tmo) begin e.stall_cyc = 1 + TMO; e.req_cyc = TMO; end
      else begin
         e.req_cyc   = gnt_dly + 1;
         e.stall_cyc = 1 + gnt_dly + 1;
         if (!we && !rv_with_gnt) e.stall_cyc += wait_tmo ? TMO : rv_dly + 1;
      end
      exp_q.push_back(e);

      req_valid = 1'b1; mem_write = we; access_mode = mode; unsigned_load = uns;
      addr = a; wdata = wd;
      #1 check({tag, "_stall_idle"}, stall, 1);
      nreq = 0; nwait = 0; stc = 1; done = 1'b0;
      @(posedge clk);
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
         if (!stall) begin
            done = 1'b1;
         end else begin
            stc++;
            if (bus_req) begin
               check({tag, "_baddr"}, bus_addr, exp_q[0].baddr);
               check({tag, "_be"}, bus_be, exp_q[0].be);
               check({tag, "_we"}, bus_we, exp_q[0].we);
               if (we) check({tag, "_bwdata"}, bus_wdata, exp_q[0].bwd);
               if (we && nreq != gnt_dly) bus_rvalid = 1'b1;
               if (nreq == gnt_dly) begin
                  bus_gnt = 1'b1;
                  if (rv_with_gnt) begin bus_rvalid = 1'b1; bus_rdata = brd; end
               end
               nreq++;
            end else begin
               if (nwait == rv_dly) begin bus_rvalid = 1'b1; bus_rdata = brd; end
               nwait++;
            end
            @(posedge clk);
         end
      end
      check({tag, "_completed"}, done, 1);
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rdata, e.rdata);
      check({tag, "_bus_err"}, bus_err, e.err);
      check({tag, "_misaligned"}, misaligned, e.mis);
      check({tag, "_stall_cycles"}, stc, e.stall_cyc);
      check({tag, "_req_cycles"}, nreq, e.req_cyc);
      check({tag, "_req_drop"}, bus_req, 0);
      bus_rvalid = 1'b1;
      req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      bus_rvalid = 1'b0;
      check({tag, "_idle_stall"}, stall, 0);
      check({tag, "_idle_rdata"}, rdata, 0);
      check({tag, "_idle_err"}, bus_err, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req_valid = 1'b0; mem_write = 1'b0; access_mode = 2'b00;
      unsigned_load = 1'b0; addr = 32'd0; wdata = 32'd0;
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_stall", stall, 0);
      check("rst_bus_req", bus_req, 0);
      check("rst_bus_addr", bus_addr, 0);
      check("rst_bus_be", bus_be, 0);
      check("rst_bus_wdata", bus_wdata, 0);
      check("rst_rdata", rdata, 0);
      reset = 1'b0;
      @(posedge clk); @(negedge clk);

      run_access("st_byte",   1, 2'b00, 0, 32'h1003, 32'h000000AB, 0, 0, 0, 32'h0);
      run_access("ld_half_s", 0, 2'b01, 0, 32'h2002, 32'h0, 0, 0, 0, 32'h8001_1234);
      run_access("ld_half_u", 0, 2'b01, 1, 32'h2002, 32'h0, 0, 0, 0, 32'h8001_1234);
      run_access("ld_byte_d", 0, 2'b00, 0, 32'h0011, 32'h0, 3, 1, 0, 32'h0000_7F00);
      run_access("tmo_req",   1, 2'b10, 0, 32'h4000, 32'h1234_5678, -1, 0, 0, 32'h0);
      run_access("tmo_wait",  0, 2'b10, 0, 32'h4004, 32'h0, 0, 0, -1, 32'hDEAD_BEEF);
      run_access("mis_word",  0, 2'b10, 0, 32'h3002, 32'h0, 0, 0, 0, 32'hCAFE_F00D);
      run_access("st_half",   1, 2'b01, 0, 32'h0002, 32'h1234_ABCD, 1, 0, 0, 32'h0);
      run_access("ld_b_neg",  0, 2'b00, 0, 32'h0103, 32'h0, 0, 0, 2, 32'h8500_0000);
      run_access("ld_w_mode3",0, 2'b11, 1, 32'h0200, 32'h0, 0, 1, 0, 32'h8765_4321);

      for (int i = 0; i < 16; i++) begin
         run_access("rnd", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, $urandom,
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom);
      end

      // Reset while waiting for read data.
      req_valid = 1'b1; mem_write = 1'b0; access_mode = 2'b10; addr = 32'h5000;
      @(posedge clk); @(negedge clk);
      bus_gnt = 1'b1;
      @(posedge clk); @(negedge clk);
      bus_gnt = 1'b0;
      check("rstw_in_wait_stall", stall, 1);
      check("rstw_in_wait_req", bus_req, 0);
      reset = 1'b1;
      #1;
      check("rstw_stall", stall, 0);
      check("rstw_bus_req", bus_req, 0);
      check("rstw_bus_addr", bus_addr, 0);
      @(posedge clk); @(negedge clk);
      reset = 1'b0; req_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      check("rstw_idle_stall", stall, 0);
      run_access("after_rst", 0, 2'b00, 1, 32'h5002, 32'h0, 0, 0, 0, 32'h00C3_0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Responder side of the core's data-memory control signals: mem_write, access_mode and unsigned_load, as produced by the decoder's MemWrite, AccessMode and funct3.
- Turns one load/store request into a request/grant/response transaction on a word-wide data bus that can stall.
- Generates byte enables and replicated write data; extracts and sign/zero-extends load data.
- Holds the core in stall until the access completes.

Parameters:
- TIMEOUT, 255: bus-progress timeout in cycles; 0 disables the timeout.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- req_valid  in  1  core has a load/store this cycle; held until stall=0
- mem_write  in  1  1=store, 0=load
- access_mode  in  2  00 byte, 01 half, 10 word, 11 treated as word
- unsigned_load  in  1  zero-extend load (LBU/LHU)
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-aligned
- stall  out  1  hold PC/pipeline
- rdata  out  32  extended load result, valid in DONE
- misaligned  out  1  access misaligned (DONE cycle)
- bus_err  out  1  timeout occurred (DONE cycle)
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  ADDR_W  word address, addr[1:0] forced to 00
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated write data
- bus_gnt  in  1  request accepted
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read data

Behaviour:
- Reset values: state IDLE; all outputs 0 (stall, rdata, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata).
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid, register addr, wdata, mode, mem_write and unsigned_load, then go to REQ.
  - If MISALIGN_TRAP_EN is defined and the access is misaligned, go to DONE with misaligned=1 and no bus transaction.
- REQ:
  - bus_req=1; bus_we, bus_addr, bus_be and bus_wdata are driven from the registered request and held stable until bus_gnt.
  - On gnt: a store goes to DONE; a load goes to WAIT.
  - A load whose rvalid arrives in the same cycle as gnt captures data and goes to DONE.
- WAIT: on bus_rvalid, capture extended data and go to DONE.
- DONE:
  - stall=0; rdata, misaligned and bus_err are valid for exactly this cycle.
  - Next state is IDLE.
  - A new req_valid is sampled in IDLE only, so back-to-back accesses are spaced by at least one IDLE cycle.
- Latency:
  - Store with immediate gnt: 3 cycles stalled-to-release (IDLE, REQ, DONE).
  - Load with gnt and rvalid one cycle apart: 4 cycles.
- Byte enables:
  - Byte: be = 0001 << addr[1:0].
  - Half: be = 0011 << (2*addr[1]).
  - Word: 1111.
- Write data:
  - Byte: wdata[7:0] replicated ×4.
  - Half: wdata[15:0] replicated ×2.
  - Word: as-is.
- Load extract:
  - Select the lane by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend unless unsigned_load; for word, unsigned_load is ignored.
- Timeout:
  - A counter clears on entry to REQ or WAIT and increments each cycle without gnt (REQ) or rvalid (WAIT).
  - On reaching TIMEOUT-1, go to DONE with bus_err=1 and rdata=0.
  - bus_req drops in DONE.
- Stray inputs: bus_rvalid in IDLE, REQ-before-gnt (store), or DONE is ignored.
- Reset mid-transaction: asynchronous reset forces IDLE immediately; bus_req deasserts without waiting for gnt. The bus side must tolerate the abandoned request.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠00) skips the bus.
  - DONE asserts misaligned=1; rdata=0.
  - A misaligned store writes nothing.
- Undefined:
  - misaligned is tied 0.
  - Low address bits below the access size are ignored (half uses addr[1], word uses lane 0), and the access proceeds normally.

Test Plan:
- Store byte: addr=0x1003, wdata=0x000000AB, gnt on first REQ cycle → bus_addr=0x1000, be=1000, bus_wdata=0xABABABAB, bus_we=1; stall high for 2 cycles, low in DONE.
- Load half signed: addr=0x2002, bus_rdata=0x8001_1234 one cycle after gnt → rdata=0xFFFF8001. Repeat with unsigned_load=1 → rdata=0x00008001.
- Load byte, gnt delayed 3 cycles and rvalid same cycle as gnt: addr=0x11, bus_rdata=0x00007F00 → bus_req held 4 cycles with stable addr/be=0010; rdata=0x0000007F.
- Timeout with TIMEOUT=8: gnt never asserted → DONE after 8 REQ cycles, bus_err=1, rdata=0, next state IDLE.
- Misaligned word load, addr=0x3002:
  - With MISALIGN_TRAP_EN: no bus_req; misaligned=1 in DONE.
  - Without: bus_addr=0x3000, be=1111, normal load.
- Reset asserted in WAIT → bus_req and stall 0 in the same cycle, state IDLE; a subsequent load completes normally.
